// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave pin front end: synchronises the SCLK/CS_n/MOSI pads, detects edges,
// deserialises MOSI into bytes and serialises reply bytes onto MISO, MSB first.
module spi_slave_frontend #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       frame_active,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_partial
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_n_prev;

    logic       sclk_s, cs_n_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic       load_pending;

    // Chains reset to the idle pad levels so releasing reset never fakes an edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_n_sync <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_n_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_prev <= sclk_s;
            cs_n_prev <= cs_n_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s &  sclk_prev;
    assign cs_fall   = ~cs_n_s &  cs_n_prev;
    assign cs_rise   =  cs_n_s & ~cs_n_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= 3'd0;
            rx_shift      <= 7'd0;
            tx_shift      <= 8'd0;
            load_pending  <= 1'b0;
            rx_data       <= 8'd0;
            rx_valid      <= 1'b0;
            tx_req        <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            frame_partial <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle, so every branch below only raises them.
            rx_valid      <= 1'b0;
            tx_req        <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            frame_partial <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state        <= ST_ACTIVE;
                        frame_start  <= 1'b1;
                        tx_shift     <= tx_data;
                        bit_cnt      <= 3'd0;
                        tx_req       <= 1'b1;
                        load_pending <= 1'b0;
                    end
                end

                default: begin
                    // CS rising wins over any SCLK edge seen in the same cycle.
                    if (cs_rise) begin
                        state         <= ST_IDLE;
                        frame_end     <= 1'b1;
                        frame_partial <= (bit_cnt != 3'd0);
                        bit_cnt       <= 3'd0;
                        load_pending  <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[5:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data      <= {rx_shift, mosi_s};
                            rx_valid     <= 1'b1;
                            tx_req       <= 1'b1;
                            load_pending <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (load_pending) begin
                            tx_shift     <= tx_data;
                            load_pending <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    assign frame_active = (state == ST_ACTIVE);
    assign miso_oe_o    = frame_active;
    assign miso_o       = tx_shift[7];

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed bench for spi_slave_frontend: a mode-0 master model at clk/10 drives the pads,
// a monitor counts strobes, and table vectors plus hand sequences check the results.
module tb_spi_slave_frontend;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk_i = 1'b0;
    logic       cs_n_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       miso_o, miso_oe_o, rx_valid, tx_req;
    logic       frame_active, frame_start, frame_end, frame_partial;
    logic [7:0] rx_data;

    int n_cmp  = 0;
    int n_fail = 0;

    spi_slave_frontend #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk_i(sclk_i), .cs_n_i(cs_n_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_req(tx_req), .frame_active(frame_active),
        .frame_start(frame_start), .frame_end(frame_end), .frame_partial(frame_partial)
    );

    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling clk edge.
    int         rx_cnt = 0, txr_cnt = 0, fs_cnt = 0, fe_cnt = 0;
    logic       last_partial = 1'b0;
    logic [7:0] rx_log [64];
    logic       prev_rxv = 1'b0, prev_txr = 1'b0, wide_pulse = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 64] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (tx_req)      txr_cnt = txr_cnt + 1;
        if (frame_start) fs_cnt  = fs_cnt + 1;
        if (frame_end) begin
            fe_cnt       = fe_cnt + 1;
            last_partial = frame_partial;
        end
        if ((rx_valid && prev_rxv) || (tx_req && prev_txr)) wide_pulse = 1'b1;
        prev_rxv = rx_valid;
        prev_txr = tx_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic half();
        cycles(5);
    endtask

    // Shifts nbits of m (MSB first) and returns what was seen on MISO before each rise.
    task automatic xfer(input logic [7:0] m, input int nbits, output logic [7:0] s);
        s = 8'd0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi_i = m[i];
            half();
            s[i]   = miso_o;
            sclk_i = 1'b1;
            half();
            sclk_i = 1'b0;
        end
    endtask

    task automatic start_frame();
        cs_n_i = 1'b0;
        cycles(6);
    endtask

    task automatic end_frame();
        half();
        cs_n_i = 1'b1;
        cycles(10);
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         rx0, txr0, fs0, fe0;
        logic [7:0] got;
        logic [7:0] got_b [3];

        vecs[0] = '{mosi: 8'h3C, tx: 8'hA5, exp_rx: 8'h3C, exp_miso: 8'hA5};
        vecs[1] = '{mosi: 8'h00, tx: 8'hFF, exp_rx: 8'h00, exp_miso: 8'hFF};
        vecs[2] = '{mosi: 8'hFF, tx: 8'h00, exp_rx: 8'hFF, exp_miso: 8'h00};
        vecs[3] = '{mosi: 8'h81, tx: 8'h7E, exp_rx: 8'h81, exp_miso: 8'h7E};
        vecs[4] = '{mosi: 8'h55, tx: 8'hAA, exp_rx: 8'h55, exp_miso: 8'hAA};

        // Reset with random pads: every output low.
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sclk_i  = 1'($urandom);
            cs_n_i  = 1'($urandom);
            mosi_i  = 1'($urandom);
            tx_data = 8'($urandom);
            #1;
            check("reset_outputs",
                  {miso_o, miso_oe_o, rx_data, rx_valid, tx_req, frame_active,
                   frame_start, frame_end, frame_partial}, 32'd0);
        end
        sclk_i = 1'b0; cs_n_i = 1'b1; mosi_i = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(4);

        // SCLK toggling while deselected produces nothing.
        rx0 = rx_cnt; txr0 = txr_cnt; fs0 = fs_cnt;
        for (int i = 0; i < 6; i++) begin
            sclk_i = ~sclk_i;
            mosi_i = ~mosi_i;
            half();
        end
        sclk_i = 1'b0; mosi_i = 1'b0;
        cycles(6);
        check("idle_rx_valid", rx_cnt - rx0, 0);
        check("idle_tx_req", txr_cnt - txr0, 0);
        check("idle_frame_start", fs_cnt - fs0, 0);
        check("idle_miso_oe", miso_oe_o, 1'b0);

        // Table: single-byte frames.
        foreach (vecs[k]) begin
            rx0 = rx_cnt; txr0 = txr_cnt; fs0 = fs_cnt; fe0 = fe_cnt;
            tx_data = vecs[k].tx;
            start_frame();
            check("frame_active_oe", {frame_active, miso_oe_o}, 2'b11);
            xfer(vecs[k].mosi, 8, got);
            end_frame();
            check("vec_miso", got, vecs[k].exp_miso);
            check("vec_rx_count", rx_cnt - rx0, 1);
            check("vec_rx_data", rx_log[rx0 % 64], vecs[k].exp_rx);
            check("vec_tx_req", txr_cnt - txr0, 2);
            check("vec_frame_start", fs_cnt - fs0, 1);
            check("vec_frame_end", fe_cnt - fe0, 1);
            check("vec_partial", last_partial, 1'b0);
        end
        check("idle_after_frames", {frame_active, miso_oe_o}, 2'b00);

        // Back-to-back bytes; tx_data advances once the previous load point has passed.
        rx0 = rx_cnt; txr0 = txr_cnt;
        tx_data = 8'h11;
        start_frame();
        tx_data = 8'h22;
        xfer(8'hDE, 8, got_b[0]);
        cycles(5);
        tx_data = 8'h33;
        xfer(8'hAD, 8, got_b[1]);
        cycles(5);
        tx_data = 8'h44;
        xfer(8'hBE, 8, got_b[2]);
        end_frame();
        check("b2b_rx_count", rx_cnt - rx0, 3);
        check("b2b_rx0", rx_log[(rx0 + 0) % 64], 8'hDE);
        check("b2b_rx1", rx_log[(rx0 + 1) % 64], 8'hAD);
        check("b2b_rx2", rx_log[(rx0 + 2) % 64], 8'hBE);
        check("b2b_miso0", got_b[0], 8'h11);
        check("b2b_miso1", got_b[1], 8'h22);
        check("b2b_miso2", got_b[2], 8'h33);
        check("b2b_tx_req", txr_cnt - txr0, 4);

        // Partial frame: 5 bits then deselect.
        rx0 = rx_cnt; fe0 = fe_cnt;
        tx_data = 8'hC3;
        start_frame();
        xfer(8'hF0, 5, got);
        end_frame();
        check("partial_frame_end", fe_cnt - fe0, 1);
        check("partial_flag", last_partial, 1'b1);
        check("partial_no_rx", rx_cnt - rx0, 0);
        check("partial_rx_hold", rx_data, 8'hBE);
        start_frame();
        xfer(8'h5A, 8, got);
        end_frame();
        check("after_partial_rx", rx_log[rx0 % 64], 8'h5A);
        check("after_partial_miso", got, 8'hC3);

        // Coincident CS rise and 8th SCLK rise: the frame ends and the byte is dropped.
        rx0 = rx_cnt; fe0 = fe_cnt;
        tx_data = 8'h0F;
        start_frame();
        xfer(8'hE7, 7, got);
        mosi_i = 1'b1;
        half();
        sclk_i = 1'b1;
        cs_n_i = 1'b1;
        cycles(10);
        sclk_i = 1'b0;
        cycles(10);
        check("coinc_frame_end", fe_cnt - fe0, 1);
        check("coinc_no_rx", rx_cnt - rx0, 0);
        check("coinc_partial", last_partial, 1'b1);
        check("coinc_idle", frame_active, 1'b0);
        start_frame();
        xfer(8'h96, 8, got);
        end_frame();
        check("after_coinc_rx", rx_log[rx0 % 64], 8'h96);

        // Reset three bits into a byte.
        tx_data = 8'hFF;
        start_frame();
        xfer(8'h24, 3, got);
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              {miso_o, miso_oe_o, rx_data, frame_active}, 32'd0);
        cs_n_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(5);
        check("midrst_idle", {frame_active, miso_oe_o}, 2'b00);
        rx0 = rx_cnt;
        tx_data = 8'h3C;
        start_frame();
        xfer(8'h81, 8, got);
        end_frame();
        check("midrst_rx_count", rx_cnt - rx0, 1);
        check("midrst_rx_data", rx_data, 8'h81);
        check("midrst_miso", got, 8'h3C);

        check("single_cycle_strobes", wide_pulse, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
